// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between a core request port and a
// word-wide memory port; handles sizing, byte lanes, extension, error detection and ack timeout.
module lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE. The memory side holds mem_req until mem_ack
    // (or timeout), and resp_valid is a single-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        req_size;
    logic [OFF_W-1:0]  req_off;
    logic              req_illegal;
    logic              req_misaligned;
    logic              req_bad;
    logic [7:0]        size_mask;
    logic [NB-1:0]     req_strb;
    logic [XLEN-1:0]   req_wdata_sh;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;

    // Request classification and store lane placement, from the live request inputs.
    always_comb begin
        req_size    = req_funct3[1:0];
        req_off     = req_addr[OFF_W-1:0];
        req_illegal = (req_funct3 == 3'b111)
                   || (req_we && req_funct3[2])
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        case (req_size)
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            2'd3:    req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
        req_bad = req_illegal || req_misaligned;

        case (req_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        req_strb     = size_mask[NB-1:0] << req_off;
        req_wdata_sh = req_wdata << {req_off, 3'b000};
    end

    // Load result: move the addressed lane to bit 0, then size and extend.
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_ext = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_ext = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_ext = XLEN'(ld_shift[7:0]);
            3'b101:  ld_ext = XLEN'(ld_shift[15:0]);
            3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = req_off;
                    if (req_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = S_MEM;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wdata_d = req_we ? req_wdata_sh : '0;
                        mem_wstrb_d = req_we ? req_strb : '0;
                    end
                end
            end

            S_MEM: begin
                // An ack on the final counted cycle takes priority over the timeout.
                if (mem_ack) begin
                    state_d     = S_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    err_d       = 1'b0;
                    rdata_d     = mem_we_q ? '0 : ld_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized transactions against a byte-arithmetic reference model.
module tb_lsu_ctrl;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;
    logic [XLEN:0] exp_q[$];

    lsu_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    // Reference model: plain byte arithmetic on the request fields.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rd,
                                  output bit bad, output logic [31:0] e_addr,
                                  output logic [31:0] e_wdata, output logic [3:0] e_strb,
                                  output logic [31:0] e_rdata);
        int nbytes;
        int off;
        logic [63:0] mask;
        logic [63:0] v;
        nbytes  = 1 << (int'(f3) % 4);
        off     = int'(addr % 4);
        bad     = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (we && f3 >= 3'd4)
               || ((addr % nbytes) != 0);
        e_addr  = addr - off;
        e_strb  = we ? 4'(((1 << nbytes) - 1) << off) : 4'd0;
        e_wdata = 32'({32'd0, wdata} << (8 * off));
        mask    = (64'd1 << (8 * nbytes)) - 64'd1;
        v       = ({32'd0, rd} >> (8 * off)) & mask;
        if (f3 < 3'd4 && v[8 * nbytes - 1]) v = v | ~mask;
        e_rdata = we ? 32'd0 : v[31:0];
    endfunction

    // Driver: one transaction from an IDLE negedge; ack_at = MEM cycle carrying mem_ack (0 = never).
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input int ack_at);
        bit bad;
        bit done;
        logic [31:0] ea, ew, er;
        logic [3:0]  es;
        logic [XLEN:0] e;
        model(we, f3, addr, wdata, rd, bad, ea, ew, es, er);
        check("ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        last_acc   = cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (bad) begin
            exp_q.push_back({1'b1, 32'd0});
            check("err_no_memreq", mem_req, 0);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT && !done; k++) begin
                check("mem_req_held", mem_req, 1);
                check("mem_we", mem_we, we);
                check("mem_addr", mem_addr, ea);
                check("mem_wstrb", mem_wstrb, es);
                if (we) check("mem_wdata", mem_wdata, ew);
                check("ready_low_mem", req_ready, 0);
                check("no_resp_in_mem", resp_valid, 0);
                if (k == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                    done      = 1'b1;
                end
                @(posedge clk);
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            exp_q.push_back(done ? {1'b0, er} : {1'b1, 32'd0});
            check("mem_req_dropped", mem_req, 0);
        end
        check("resp_valid", resp_valid, 1);
        check("ready_low_resp", req_ready, 0);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("resp_err", resp_err, e[XLEN]);
            check("resp_rdata", resp_rdata, e[XLEN-1:0]);
        end
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
        check("ready_after_resp", req_ready, 1);
    endtask

    initial begin
        int prev;
        bit rwe;
        logic [2:0] rf3;
        logic [31:0] raddr;
        int r;
        int ack;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        rst = 1'b1;

        // Directed cases
        txn(1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 1);
        txn(1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_1234, 2);
        txn(1'b0, 3'b101, 32'h2002, 32'h0, 32'h8001_1234, 1);
        txn(1'b0, 3'b010, 32'h2001, 32'h0, 32'h0, 1);
        txn(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1);
        txn(1'b1, 3'b100, 32'h2000, 32'h0, 32'h0, 1);
        txn(1'b0, 3'b010, 32'h3000, 32'h0, 32'hCAFE_F00D, 0);
        txn(1'b0, 3'b010, 32'h3004, 32'h0, 32'hCAFE_F00D, TIMEOUT);
        txn(1'b0, 3'b000, 32'h4001, 32'h0, 32'h0000_8000, 1);

        // Back-to-back LB / SW with a one-cycle ack
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 3'b000, 32'h5000 + i, 32'h0, $urandom, 1);
            prev = last_acc;
            txn(1'b1, 3'b010, 32'h6000 + 4 * i, $urandom, 32'h0, 1);
            check("b2b_period", last_acc - prev, 3);
        end

        // Reset three cycles into MEM, then a stray late ack
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h7000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("pre_rst_mem_req", mem_req, 1);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check("async_drop_mem_req", mem_req, 0);
        check("rst_in_mem_ready", req_ready, 1);
        check("rst_in_mem_no_resp", resp_valid, 0);
        @(negedge clk);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("late_ack_no_resp", resp_valid, 0);
            check("late_ack_no_memreq", mem_req, 0);
            check("late_ack_ready", req_ready, 1);
            @(negedge clk);
        end

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r == 0)      ack = 0;
            else if (r == 1) ack = TIMEOUT;
            else if (r == 2) ack = TIMEOUT - 1;
            else             ack = $urandom_range(1, 4);
            txn(rwe, rf3, raddr, $urandom, $urandom, ack);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
